// File: rtl/rv32i_types.sv
// Shared RV32I core types: opcode encodings, NOP opcode and the interlock FSM states.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    localparam logic [6:0] NOP_OPCODE = 7'h00;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FROZEN = 2'd2
    } hazard_state_t;

    // A source operand depends on rd only if it is actually read and rd is not x0.
    function automatic logic src_dep(input logic used, input logic [4:0] rs, input logic [4:0] rd);
        return used && (rs == rd) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the interlock controller (master) and the pipeline/caches it governs (slave).
interface hazard_stall_ctrl_if #(
    parameter int CNT_W  = 32,
    parameter int DATA_W = 32
);
    logic [6:0]        ID_EX_opcode;
    logic [4:0]        ID_EX_rd;
    logic              ID_EX_rdwrite;
    logic [4:0]        IF_ID_rs1;
    logic [4:0]        IF_ID_rs2;
    logic              IF_ID_rs1_used;
    logic              IF_ID_rs2_used;
    logic              EX_br_taken;
    logic              icache_read;
    logic              icache_resp;
    logic [DATA_W-1:0] icache_rdata;
    logic              dcache_read;
    logic              dcache_write;
    logic              dcache_resp;

    logic              pc_load;
    logic              IF_ID_load;
    logic              ID_EX_load;
    logic              EX_MEM_load;
    logic              MEM_WB_load;
    logic              IF_ID_flush;
    logic              ID_EX_flush;
    logic [DATA_W-1:0] if_instr;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  bubble_count;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        input  ID_EX_opcode, ID_EX_rd, ID_EX_rdwrite, IF_ID_rs1, IF_ID_rs2,
               IF_ID_rs1_used, IF_ID_rs2_used, EX_br_taken, icache_read, icache_resp,
               icache_rdata, dcache_read, dcache_write, dcache_resp,
        output pc_load, IF_ID_load, ID_EX_load, EX_MEM_load, MEM_WB_load,
               IF_ID_flush, ID_EX_flush, if_instr, stall_cycles, bubble_count, flush_count
    );

    modport slave (
        output ID_EX_opcode, ID_EX_rd, ID_EX_rdwrite, IF_ID_rs1, IF_ID_rs2,
               IF_ID_rs1_used, IF_ID_rs2_used, EX_br_taken, icache_read, icache_resp,
               icache_rdata, dcache_read, dcache_write, dcache_resp,
        input  pc_load, IF_ID_load, ID_EX_load, EX_MEM_load, MEM_WB_load,
               IF_ID_flush, ID_EX_flush, if_instr, stall_cycles, bubble_count, flush_count
    );
endinterface

// File: rtl/hazard_stall_ctrl_hold.sv
// instr_hold_buffer: keeps an I-cache word that arrived while the pipeline was frozen on the D-cache.
module instr_hold_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Capture and clear never coincide: capture only happens while frozen, when no stage loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_capture) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock controller: load-use bubbles, cache-miss freezes, deferred branch flushes.
module hazard_stall_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W  = 32,
    parameter int DATA_W = 32
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_ctrl_if.master bus
);
    hazard_state_t    r_state, w_next;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt, r_flush_cnt;

    logic              w_ihold_v;
    logic [DATA_W-1:0] w_ihold_data;
    logic w_imiss, w_dmiss, w_freeze, w_loaduse;
    logic w_pc_ld, w_ifid_ld, w_idex_ld, w_exmem_ld, w_memwb_ld;
    logic w_ifid_fl, w_idex_fl;
    logic w_flush_go, w_bubble_go, w_pend_set;

    assign w_imiss   = bus.icache_read & ~bus.icache_resp & ~w_ihold_v;
    assign w_dmiss   = (bus.dcache_read | bus.dcache_write) & ~bus.dcache_resp;
    assign w_freeze  = w_imiss | w_dmiss;
    assign w_loaduse = (bus.ID_EX_opcode == op_load) & bus.ID_EX_rdwrite &
                       (src_dep(bus.IF_ID_rs1_used, bus.IF_ID_rs1, bus.ID_EX_rd) |
                        src_dep(bus.IF_ID_rs2_used, bus.IF_ID_rs2, bus.ID_EX_rd));

    // FROZEN release follows RUN rules; BUBBLE only differs by not bubbling again.
    always_comb begin
        w_next      = r_state;
        w_pc_ld     = 1'b0;
        w_ifid_ld   = 1'b0;
        w_idex_ld   = 1'b0;
        w_exmem_ld  = 1'b0;
        w_memwb_ld  = 1'b0;
        w_ifid_fl   = 1'b0;
        w_idex_fl   = 1'b0;
        w_flush_go  = 1'b0;
        w_bubble_go = 1'b0;
        w_pend_set  = 1'b0;
        if (rst) begin
            w_next = RUN;
        end else if (w_freeze) begin
            w_next     = FROZEN;
            w_pend_set = bus.EX_br_taken;
        end else if (r_flush_pend | bus.EX_br_taken) begin
            {w_pc_ld, w_ifid_ld, w_idex_ld, w_exmem_ld, w_memwb_ld} = 5'b11111;
            w_ifid_fl  = 1'b1;
            w_idex_fl  = 1'b1;
            w_flush_go = 1'b1;
            w_next     = RUN;
        end else if ((r_state != BUBBLE) && w_loaduse) begin
            {w_idex_ld, w_exmem_ld, w_memwb_ld} = 3'b111;
            w_idex_fl   = 1'b1;
            w_bubble_go = 1'b1;
            w_next      = BUBBLE;
        end else begin
            {w_pc_ld, w_ifid_ld, w_idex_ld, w_exmem_ld, w_memwb_ld} = 5'b11111;
            w_next = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RUN;
            r_flush_pend <= 1'b0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_pend_set)
                r_flush_pend <= 1'b1;
            else if (w_flush_go)
                r_flush_pend <= 1'b0;
            if (w_freeze)    r_stall_cnt  <= r_stall_cnt  + CNT_W'(1);
            if (w_bubble_go) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            if (w_flush_go)  r_flush_cnt  <= r_flush_cnt  + CNT_W'(1);
        end
    end

    // A flush always loads IF/ID, so a wrong-path held word is dropped by the same clear.
    instr_hold_buffer #(.DATA_W(DATA_W)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_capture (bus.icache_resp & w_dmiss & ~w_ihold_v),
        .i_clear   (w_ifid_ld),
        .i_data    (bus.icache_rdata),
        .o_valid   (w_ihold_v),
        .o_data    (w_ihold_data)
    );

    assign bus.pc_load      = w_pc_ld;
    assign bus.IF_ID_load   = w_ifid_ld;
    assign bus.ID_EX_load   = w_idex_ld;
    assign bus.EX_MEM_load  = w_exmem_ld;
    assign bus.MEM_WB_load  = w_memwb_ld;
    assign bus.IF_ID_flush  = w_ifid_fl;
    assign bus.ID_EX_flush  = w_idex_fl;
    assign bus.if_instr     = rst ? '0 : (w_ihold_v ? w_ihold_data : bus.icache_rdata);
    assign bus.stall_cycles = r_stall_cnt;
    assign bus.bubble_count = r_bubble_cnt;
    assign bus.flush_count  = r_flush_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, freezes, held fetch word, deferred flush, reset.
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(32), .DATA_W(32)) bus ();

    hazard_stall_ctrl #(.CNT_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] loads();
        return {27'd0, bus.pc_load, bus.IF_ID_load, bus.ID_EX_load, bus.EX_MEM_load, bus.MEM_WB_load};
    endfunction

    function automatic logic [31:0] flushes();
        return {30'd0, bus.IF_ID_flush, bus.ID_EX_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ID_EX_opcode   = 7'h00;
        bus.ID_EX_rd       = 5'd0;
        bus.ID_EX_rdwrite  = 1'b0;
        bus.IF_ID_rs1      = 5'd0;
        bus.IF_ID_rs2      = 5'd0;
        bus.IF_ID_rs1_used = 1'b0;
        bus.IF_ID_rs2_used = 1'b0;
        bus.EX_br_taken    = 1'b0;
        bus.icache_read    = 1'b0;
        bus.icache_resp    = 1'b0;
        bus.icache_rdata   = 32'h0;
        bus.dcache_read    = 1'b0;
        bus.dcache_write   = 1'b0;
        bus.dcache_resp    = 1'b0;
    endtask

    task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.ID_EX_opcode   = 7'b0000011;
        bus.ID_EX_rd       = rd;
        bus.ID_EX_rdwrite  = 1'b1;
        bus.IF_ID_rs1      = rs1;
        bus.IF_ID_rs2      = rs2;
        bus.IF_ID_rs1_used = 1'b1;
        bus.IF_ID_rs2_used = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        bus.icache_rdata = 32'h1234_5678;
        #2;
        chk("rst_loads", loads(), 32'h0);
        chk("rst_flush", flushes(), 32'h0);
        chk("rst_instr", bus.if_instr, 32'h0);
        chk("rst_stall", bus.stall_cycles, 32'h0);
        chk("rst_bubble", bus.bubble_count, 32'h0);
        chk("rst_flushcnt", bus.flush_count, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("run_loads", loads(), 32'h1f);

        // 1: lw x5 ; add x6,x5,x1 -> one bubble
        tick();
        set_lw(5'd5, 5'd5, 5'd1);
        #1;
        chk("lu_loads", loads(), 32'h07);
        chk("lu_flush", flushes(), 32'h1);
        tick();
        chk("lu_bubble_cnt", bus.bubble_count, 32'd1);
        idle();
        #1;
        chk("lu_after_loads", loads(), 32'h1f);
        chk("lu_after_flush", flushes(), 32'h0);

        // 2: lw x0 ; add x6,x0,x0 -> no bubble
        tick();
        set_lw(5'd0, 5'd0, 5'd0);
        #1;
        chk("x0_loads", loads(), 32'h1f);
        tick();
        chk("x0_bubble_cnt", bus.bubble_count, 32'd1);

        // 3: dcache miss four cycles, response on the fifth
        idle();
        bus.dcache_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("dmiss_loads%0d", i), loads(), 32'h0);
            tick();
        end
        chk("dmiss_stall", bus.stall_cycles, 32'd4);
        bus.dcache_resp = 1'b1;
        #1;
        chk("dmiss_release", loads(), 32'h1f);
        tick();
        chk("dmiss_stall_after", bus.stall_cycles, 32'd4);

        // 4: I-cache word arrives during a D-cache miss and is held
        idle();
        bus.dcache_read  = 1'b1;
        bus.icache_read  = 1'b1;
        bus.icache_resp  = 1'b1;
        bus.icache_rdata = 32'h00A0_0093;
        #1;
        chk("hold_cap_loads", loads(), 32'h0);
        tick();
        bus.icache_resp  = 1'b0;
        bus.icache_rdata = 32'hDEAD_BEEF;
        #1;
        chk("hold_instr", bus.if_instr, 32'h00A0_0093);
        tick();
        tick();
        bus.dcache_resp = 1'b1;
        #1;
        chk("hold_rel_loads", loads(), 32'h1f);
        chk("hold_rel_instr", bus.if_instr, 32'h00A0_0093);
        tick();
        chk("hold_stall", bus.stall_cycles, 32'd7);
        idle();
        bus.icache_rdata = 32'hDEAD_BEEF;
        #1;
        chk("hold_cleared", bus.if_instr, 32'hDEAD_BEEF);

        // Simultaneous I and D responses: advance, no capture
        tick();
        bus.dcache_read  = 1'b1;
        bus.dcache_resp  = 1'b1;
        bus.icache_read  = 1'b1;
        bus.icache_resp  = 1'b1;
        bus.icache_rdata = 32'h0000_0013;
        #1;
        chk("both_resp_loads", loads(), 32'h1f);
        tick();
        idle();
        bus.icache_rdata = 32'hCAFE_F00D;
        #1;
        chk("both_resp_nocap", bus.if_instr, 32'hCAFE_F00D);

        // 5: branch taken under a D-cache miss -> flush deferred to release
        tick();
        idle();
        bus.dcache_read = 1'b1;
        bus.EX_br_taken = 1'b1;
        #1;
        chk("br_frz_loads", loads(), 32'h0);
        chk("br_frz_flush", flushes(), 32'h0);
        tick();
        bus.EX_br_taken = 1'b0;
        #1;
        chk("br_frz2_flush", flushes(), 32'h0);
        tick();
        bus.dcache_resp = 1'b1;
        #1;
        chk("br_rel_loads", loads(), 32'h1f);
        chk("br_rel_flush", flushes(), 32'h3);
        tick();
        chk("br_flushcnt", bus.flush_count, 32'd1);
        idle();
        #1;
        chk("br_pend_clear", flushes(), 32'h0);
        tick();
        set_lw(5'd5, 5'd5, 5'd1);
        bus.EX_br_taken = 1'b1;
        #1;
        chk("br_lu_loads", loads(), 32'h1f);
        chk("br_lu_flush", flushes(), 32'h3);
        tick();
        chk("br_lu_flushcnt", bus.flush_count, 32'd2);
        chk("br_lu_bubble", bus.bubble_count, 32'd1);

        // 6: reset during a freeze with a held word
        idle();
        bus.dcache_read  = 1'b1;
        bus.icache_read  = 1'b1;
        bus.icache_resp  = 1'b1;
        bus.icache_rdata = 32'h0000_0013;
        tick();
        bus.icache_resp  = 1'b0;
        bus.icache_rdata = 32'h5555_5555;
        #1;
        chk("rst6_held", bus.if_instr, 32'h0000_0013);
        rst = 1'b1;
        #1;
        chk("rst6_loads", loads(), 32'h0);
        chk("rst6_instr", bus.if_instr, 32'h0);
        chk("rst6_stall", bus.stall_cycles, 32'h0);
        chk("rst6_flushcnt", bus.flush_count, 32'h0);
        chk("rst6_bubble", bus.bubble_count, 32'h0);
        rst = 1'b0;
        idle();
        bus.icache_rdata = 32'h5555_5555;
        #1;
        chk("rst6_hold_gone", bus.if_instr, 32'h5555_5555);
        chk("rst6_run_loads", loads(), 32'h1f);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
